// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_P0 = 1'b0,
      PORT_P1 = 1'b1
   } port_sel_t;

   // Wide enough for the full LATENCY range of 1..15.
   localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and data-memory drive of the arbiter; slave is the arbiter side.
interface dmem_arbiter_if #(
   parameter int unsigned ADDRESS_SIZE = 32,
   parameter int unsigned DATA_SIZE    = 32
);
   logic                    p0_req;
   logic                    p0_we;
   logic [ADDRESS_SIZE-1:0] p0_addr;
   logic [DATA_SIZE-1:0]    p0_wdata;
   logic [DATA_SIZE-1:0]    p0_rdata;
   logic                    p0_done;
   logic                    p0_stall;

   logic                    p1_req;
   logic                    p1_we;
   logic [ADDRESS_SIZE-1:0] p1_addr;
   logic [DATA_SIZE-1:0]    p1_wdata;
   logic [DATA_SIZE-1:0]    p1_rdata;
   logic                    p1_done;

   logic                    dm_write_enable;
   logic [ADDRESS_SIZE-1:0] dm_write_address;
   logic [DATA_SIZE-1:0]    dm_write_data;
   logic [ADDRESS_SIZE-1:0] dm_read_address;
   logic [DATA_SIZE-1:0]    dm_read_data;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_rdata, p0_done, p0_stall,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_rdata, p1_done,
      input  dm_write_enable, dm_write_address, dm_write_data, dm_read_address,
      output dm_read_data
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_rdata, p0_done, p0_stall,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_rdata, p1_done,
      output dm_write_enable, dm_write_address, dm_write_data, dm_read_address,
      input  dm_read_data
   );
endinterface

// File: rtl/dmem_rr_select.sv
// Fixed-priority p0 arbitration with a starvation escape for p1.
module dmem_rr_select
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      p0_req,
   input  logic      p1_req,
   input  logic      grant_en,
   output logic      any_req_c,
   output port_sel_t sel_c
);
   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved_c;

   assign starved_c = p1_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
   assign any_req_c = p0_req | p1_req;
   assign sel_c     = (p1_req && (!p0_req || starved_c)) ? PORT_P1 : PORT_P0;

   // Counts p0 grants taken while p1 is waiting; any idle p1 clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!p1_req) begin
         starve_cnt <= '0;
      end else if (grant_en && any_req_c) begin
         if (sel_c == PORT_P1)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant, single-cycle store or LATENCY-cycle load, done pulse.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDRESS_SIZE = 32,
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clock,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   arb_state_t              state;
   port_sel_t               win_sel;
   logic                    win_we;
   logic [LAT_W-1:0]        lat_cnt;
   logic                    p0_done;
   logic                    p1_done;
   logic [DATA_SIZE-1:0]    p0_rdata;
   logic [DATA_SIZE-1:0]    p1_rdata;
   logic                    dm_write_enable;
   logic [ADDRESS_SIZE-1:0] dm_write_address;
   logic [DATA_SIZE-1:0]    dm_write_data;
   logic [ADDRESS_SIZE-1:0] dm_read_address;

   logic                    any_req_c;
   port_sel_t               sel_c;
   logic                    req_we_c;
   logic [ADDRESS_SIZE-1:0] req_addr_c;
   logic [DATA_SIZE-1:0]    req_wdata_c;

   dmem_rr_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
      .clock     (clock),
      .reset     (reset),
      .p0_req    (bus.p0_req),
      .p1_req    (bus.p1_req),
      .grant_en  (state == IDLE),
      .any_req_c (any_req_c),
      .sel_c     (sel_c)
   );

   assign req_we_c    = (sel_c == PORT_P1) ? bus.p1_we    : bus.p0_we;
   assign req_addr_c  = (sel_c == PORT_P1) ? bus.p1_addr  : bus.p0_addr;
   assign req_wdata_c = (sel_c == PORT_P1) ? bus.p1_wdata : bus.p0_wdata;

   // The dm_* registers double as the latched transfer; they are zero outside ACCESS.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         win_sel          <= PORT_P0;
         win_we           <= 1'b0;
         lat_cnt          <= '0;
         p0_done          <= 1'b0;
         p1_done          <= 1'b0;
         p0_rdata         <= '0;
         p1_rdata         <= '0;
         dm_write_enable  <= 1'b0;
         dm_write_address <= '0;
         dm_write_data    <= '0;
         dm_read_address  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  win_sel <= sel_c;
                  win_we  <= req_we_c;
                  lat_cnt <= LAT_W'(LATENCY - 1);
                  if (req_we_c) begin
                     dm_write_enable  <= 1'b1;
                     dm_write_address <= req_addr_c;
                     dm_write_data    <= req_wdata_c;
                  end else begin
                     dm_read_address  <= req_addr_c;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (win_we || (lat_cnt == '0)) begin
                  if (!win_we) begin
                     if (win_sel == PORT_P1) p1_rdata <= bus.dm_read_data;
                     else                    p0_rdata <= bus.dm_read_data;
                  end
                  dm_write_enable  <= 1'b0;
                  dm_write_address <= '0;
                  dm_write_data    <= '0;
                  dm_read_address  <= '0;
                  lat_cnt          <= '0;
                  p0_done          <= (win_sel == PORT_P0);
                  p1_done          <= (win_sel == PORT_P1);
                  state            <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            DONE: begin
               p0_done <= 1'b0;
               p1_done <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.p0_stall         = bus.p0_req & ~p0_done;
   assign bus.p0_done          = p0_done;
   assign bus.p1_done          = p1_done;
   assign bus.p0_rdata         = p0_rdata;
   assign bus.p1_rdata         = p1_rdata;
   assign bus.dm_write_enable  = dm_write_enable;
   assign bus.dm_write_address = dm_write_address;
   assign bus.dm_write_data    = dm_write_data;
   assign bus.dm_read_address  = dm_read_address;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions, monitor checks writes and done pulses.
module tb_dmem_arbiter;
   localparam int K_DONE0 = 0;
   localparam int K_DONE1 = 1;
   localparam int K_WRITE = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic prev_we = 1'b0;

   dmem_arbiter_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();

   dmem_arbiter #(
      .ADDRESS_SIZE(32), .DATA_SIZE(32), .LATENCY(2), .STARVE_LIMIT(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hDEADBEEF;
         32'h30:  return 32'hCAFEF00D;
         32'h44:  return 32'h0BADF00D;
         default: return a ^ 32'h5A5A0000;
      endcase
   endfunction

   assign bus.dm_read_data = mem_rd(bus.dm_read_address);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input int c);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic mon_take(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h at cyc %0d, expected none",
                  kind, a, d, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr !== a || e.data !== d || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                     kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
         end
      end
   endtask

   // Monitor: every write strobe and done pulse must match the head of the scoreboard.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.dm_write_enable) begin
            chk("we_single_cycle", 32'(prev_we), 32'd0);
            mon_take(K_WRITE, bus.dm_write_address, bus.dm_write_data);
         end else begin
            chk("idle_write_bus", bus.dm_write_address | bus.dm_write_data, 32'd0);
         end
         if (bus.p0_done) mon_take(K_DONE0, 32'd0, bus.p0_rdata);
         if (bus.p1_done) mon_take(K_DONE1, 32'd0, bus.p1_rdata);
      end
      prev_we <= bus.dm_write_enable;
   end

   task automatic issue(input int port, input logic we, input logic [31:0] a, input logic [31:0] d);
      if (port == 0) begin
         bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_req = 1'b1;
      end else begin
         bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_req = 1'b1;
      end
   endtask

   // Waits (bounded) for the port's done, then moves into the following IDLE cycle.
   task automatic wait_done(input int port, input bit drop);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         if (port == 0 ? bus.p0_done : bus.p1_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: port %0d got no done, expected one within 40 cycles", port);
      end else begin
         if (port == 0) chk("p0_stall_at_done", 32'(bus.p0_stall), 32'd0);
         @(posedge clock); #1;
         if (drop) begin
            if (port == 0) bus.p0_req = 1'b0; else bus.p1_req = 1'b0;
         end
      end
   endtask

   initial begin
      int k;
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_done", {30'd0, bus.p1_done, bus.p0_done}, 32'd0);
      chk("rst_we", 32'(bus.dm_write_enable), 32'd0);
      chk("rst_dm_addr", bus.dm_read_address | bus.dm_write_address | bus.dm_write_data, 32'd0);
      chk("rst_rdata", bus.p0_rdata | bus.p1_rdata, 32'd0);
      @(negedge clock) reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // p0 load from 0x10: done three cycles after issue, stall until then
      k = cyc;
      push(K_DONE0, 32'd0, 32'hDEADBEEF, k + 3);
      issue(0, 1'b0, 32'h10, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("p0_stall_load", 32'(bus.p0_stall), 32'd1);
         chk("rd_addr_load", bus.dm_read_address, (i == 0) ? 32'd0 : 32'h10);
      end
      wait_done(0, 1'b1);
      repeat (2) @(posedge clock);
      #1;

      // p0 store: one write strobe, done after two cycles, rdata untouched
      k = cyc;
      push(K_WRITE, 32'h20, 32'h12345678, k + 1);
      push(K_DONE0, 32'd0, 32'hDEADBEEF, k + 2);
      issue(0, 1'b1, 32'h20, 32'h12345678);
      wait_done(0, 1'b1);
      repeat (2) @(posedge clock);
      #1;

      // Simultaneous loads: p0 first, p1 granted in the IDLE after p0's DONE
      k = cyc;
      push(K_DONE0, 32'd0, 32'hCAFEF00D, k + 3);
      push(K_DONE1, 32'd0, 32'h0BADF00D, k + 7);
      issue(0, 1'b0, 32'h30, 32'd0);
      issue(1, 1'b0, 32'h44, 32'd0);
      fork
         wait_done(0, 1'b1);
         wait_done(1, 1'b1);
      join
      chk("p0_rdata_kept", bus.p0_rdata, 32'hCAFEF00D);
      repeat (2) @(posedge clock);
      #1;

      // Starvation: four p0 stores, then the waiting p1 load, then p0 again
      k = cyc;
      for (int i = 0; i < 4; i++) begin
         push(K_WRITE, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), k + 1 + 3 * i);
         push(K_DONE0, 32'd0, 32'hCAFEF00D, k + 2 + 3 * i);
      end
      push(K_DONE1, 32'd0, 32'h5A5A0050, k + 15);
      push(K_WRITE, 32'h110, 32'hA0000004, k + 17);
      push(K_DONE0, 32'd0, 32'hCAFEF00D, k + 18);
      issue(1, 1'b0, 32'h50, 32'd0);
      issue(0, 1'b1, 32'h100, 32'hA0000000);
      fork
         begin
            for (int i = 1; i <= 5; i++) begin
               wait_done(0, i == 5);
               if (i < 5) issue(0, 1'b1, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i));
            end
         end
         wait_done(1, 1'b1);
      join
      repeat (2) @(posedge clock);
      #1;

      // Reset during the second ACCESS cycle of a load aborts it silently
      k = cyc;
      issue(0, 1'b0, 32'h44, 32'd0);
      repeat (2) @(posedge clock);
      #2;
      chk("pre_rst_rd_addr", bus.dm_read_address, 32'h44);
      reset = 1'b1;
      bus.p0_req = 1'b0;
      #1;
      chk("abort_rd_addr", bus.dm_read_address, 32'd0);
      chk("abort_done", {30'd0, bus.p1_done, bus.p0_done}, 32'd0);
      chk("abort_rdata", bus.p0_rdata | bus.p1_rdata, 32'd0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      #1;
      k = cyc;
      push(K_DONE0, 32'd0, 32'hDEADBEEF, k + 3);
      issue(0, 1'b0, 32'h10, 32'd0);
      wait_done(0, 1'b1);
      repeat (4) @(posedge clock);
      #1;

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
